// File: rtl/multi_avl_rd_pkg.sv
// Shared types and helpers for the multi-channel Avalon burst-read arbiter.
// The tag struct is sized from the RD_* defaults; top-level parameters must match them.
package multi_avl_rd_pkg;
  localparam int RD_CH  = 3;
  localparam int RD_AW  = 32;
  localparam int RD_DW  = 64;
  localparam int RD_BL  = 8;
  localparam int RD_OT  = 4;
  localparam int RD_CHW = (RD_CH > 1) ? $clog2(RD_CH) : 1;

  typedef struct packed {
    logic [RD_CHW-1:0] ch;
    logic [RD_BL:0]    len;
  } rd_tag_t;

  // First requester at or after ptr, wrapping; the downward scan lets the nearest one win.
  function automatic logic [RD_CHW-1:0] rr_pick(input logic [RD_CH-1:0] req,
                                                input logic [RD_CHW-1:0] ptr);
    logic [RD_CHW-1:0] g;
    int idx;
    g = ptr;
    for (int k = RD_CH-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % RD_CH;
      if (req[idx]) g = RD_CHW'(idx);
    end
    return g;
  endfunction
endpackage

// File: rtl/multi_avl_rd_arb_if.sv
// Bus bundle: per-channel DMA read side (s_*) plus the shared SDRAM master side (m_*).
interface multi_avl_rd_arb_if
  import multi_avl_rd_pkg::*;
#(
  parameter int CH = RD_CH,
  parameter int AW = RD_AW,
  parameter int DW = RD_DW,
  parameter int BL = RD_BL
);
  logic [CH-1:0]         s_rval;
  logic [CH-1:0]         s_rrdy;
  logic [CH-1:0][BL:0]   s_rlen;
  logic [CH-1:0][AW-1:0] s_raddr;
  logic [DW-1:0]         s_rdata;
  logic [CH-1:0]         s_rdval;
  logic                  m_rval;
  logic                  m_rrdy;
  logic [BL:0]           m_rlen;
  logic [AW-1:0]         m_raddr;
  logic [DW-1:0]         m_rdata;
  logic                  m_rdval;

  // slave: the arbiter itself; master: the surrounding DMA engines and SDRAM controller
  modport slave (
    input  s_rval, s_rlen, s_raddr, m_rrdy, m_rdata, m_rdval,
    output s_rrdy, s_rdata, s_rdval, m_rval, m_rlen, m_raddr
  );
  modport master (
    output s_rval, s_rlen, s_raddr, m_rrdy, m_rdata, m_rdval,
    input  s_rrdy, s_rdata, s_rdval, m_rval, m_rlen, m_raddr
  );
endinterface

// File: rtl/multi_avl_rd_tagq.sv
// In-order FIFO of outstanding burst tags; head is the burst currently returning data.
module multi_avl_rd_tagq
  import multi_avl_rd_pkg::*;
#(
  parameter int OT = RD_OT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  rd_tag_t               din,
  output rd_tag_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(OT):0]   count
);
  localparam int PW = $clog2(OT);
  localparam int CW = PW + 1;

  rd_tag_t       mem_q [OT];
  rd_tag_t       mem_d [OT];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(OT));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multi_avl_rd_arb.sv
// Round-robin sharing of one Avalon burst-read master among CH DMA channels,
// with in-order routing of returning beats back to the issuing channel.
module multi_avl_rd_arb
  import multi_avl_rd_pkg::*;
#(
  parameter int CH = RD_CH,
  parameter int AW = RD_AW,
  parameter int DW = RD_DW,
  parameter int BL = RD_BL,
  parameter int OT = RD_OT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multi_avl_rd_arb_if.slave      bus,
  output logic                   err
);
  localparam int CW = $clog2(OT) + 1;

  logic [RD_CHW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx, m_ch_q, m_ch_d;
  logic              m_rval_q, m_rval_d;
  logic [AW-1:0]     m_raddr_q, m_raddr_d;
  logic [BL:0]       m_rlen_q, m_rlen_d, cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              push, pop, beat, slot_free, q_room, gnt, full, empty;
  logic [CW-1:0]     q_count;
  logic [CH-1:0]     s_rrdy, s_rdval;
  rd_tag_t           head, tag_in;

  assign push      = m_rval_q & bus.m_rrdy;
  assign slot_free = ~m_rval_q | bus.m_rrdy;
  // A pop never frees a slot in the same cycle; only the push that lands now is counted.
  assign q_room    = ~full & ~(push & (q_count == CW'(OT-1)));
  assign gnt       = rst_n & slot_free & q_room & (|bus.s_rval);
  assign gnt_idx   = rr_pick(bus.s_rval, rr_ptr_q);
  assign beat      = bus.m_rdval & ~empty;
  assign pop       = beat & (cnt_q == head.len - (BL+1)'(1));
  assign tag_in    = '{ch: m_ch_q, len: m_rlen_q};

  multi_avl_rd_tagq #(.OT(OT)) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (tag_in),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    m_ch_d    = m_ch_q;
    m_rval_d  = m_rval_q & ~bus.m_rrdy;
    m_raddr_d = m_raddr_q;
    m_rlen_d  = m_rlen_q;
    if (gnt) begin
      rr_ptr_d = (gnt_idx == RD_CHW'(CH-1)) ? '0 : gnt_idx + RD_CHW'(1);
      // Zero-length commands are acknowledged but never reach the SDRAM side.
      if (bus.s_rlen[gnt_idx] != '0) begin
        m_rval_d  = 1'b1;
        m_ch_d    = gnt_idx;
        m_raddr_d = bus.s_raddr[gnt_idx];
        m_rlen_d  = bus.s_rlen[gnt_idx];
      end
    end
    cnt_d = cnt_q;
    if (beat) cnt_d = pop ? '0 : cnt_q + (BL+1)'(1);
    err_d = err_q | (bus.m_rdval & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      m_ch_q    <= '0;
      m_rval_q  <= 1'b0;
      m_raddr_q <= '0;
      m_rlen_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      m_ch_q    <= m_ch_d;
      m_rval_q  <= m_rval_d;
      m_raddr_q <= m_raddr_d;
      m_rlen_q  <= m_rlen_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    s_rrdy  = '0;
    s_rdval = '0;
    if (gnt) s_rrdy[gnt_idx] = 1'b1;
    if (beat && rst_n) s_rdval[head.ch] = 1'b1;
  end

  assign bus.s_rrdy  = s_rrdy;
  assign bus.s_rdval = s_rdval;
  assign bus.s_rdata = bus.m_rdata;
  assign bus.m_rval  = m_rval_q;
  assign bus.m_raddr = m_raddr_q;
  assign bus.m_rlen  = m_rlen_q;
  assign err         = err_q;
endmodule

// File: tb/tb_multi_avl_rd_arb.sv
// Directed bench: stimulus pushes expected grants/commands/beats, a negedge monitor pops and compares.
module tb_multi_avl_rd_arb;
  typedef struct { logic [31:0] addr; logic [8:0] len; } cmd_t;
  typedef struct { logic [2:0] vld; logic [63:0] data; } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic err;
  int   checks = 0;
  int   errors = 0;
  int   exp_gnt[$];
  cmd_t exp_cmd[$];
  beat_t exp_beat[$];

  multi_avl_rd_arb_if #(.CH(3), .AW(32), .DW(64), .BL(8)) bus ();

  multi_avl_rd_arb #(.CH(3), .AW(32), .DW(64), .BL(8), .OT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_req(input int c, input logic [31:0] a, input logic [8:0] l);
    bus.s_raddr[c] = a;
    bus.s_rlen[c]  = l;
  endtask

  task automatic exp_req(input int c, input logic [31:0] a, input logic [8:0] l);
    exp_gnt.push_back(c);
    if (l != 0) exp_cmd.push_back('{a, l});
  endtask

  // Each channel in mask holds s_rval until it sees its own s_rrdy.
  task automatic issue(input logic [2:0] mask);
    logic [2:0] pend;
    int n;
    pend = mask;
    n = 0;
    bus.s_rval = pend;
    while (pend != 0 && n < 100) begin
      @(negedge clk);
      pend = pend & ~bus.s_rrdy;
      step();
      bus.s_rval = pend;
      n++;
    end
    if (pend != 0) chk("issue_timeout", 64'(pend), 64'd0);
    bus.s_rval = '0;
  endtask

  task automatic beat(input logic [2:0] vld, input logic [63:0] d);
    bus.m_rdval = 1'b1;
    bus.m_rdata = d;
    exp_beat.push_back('{vld, d});
    step();
    bus.m_rdval = 1'b0;
  endtask

  task automatic burst(input logic [2:0] vld, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) beat(vld, base + 64'(i));
  endtask

  // Monitor
  initial begin
    int    g;
    cmd_t  c;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.s_rrdy != 0) begin
          if (exp_gnt.size() == 0) chk("unexpected_grant", 64'(bus.s_rrdy), 64'd0);
          else begin
            g = exp_gnt.pop_front();
            chk("grant", 64'(bus.s_rrdy), 64'(3'b001 << g));
          end
        end
        if (bus.m_rval && bus.m_rrdy) begin
          if (exp_cmd.size() == 0) chk("unexpected_cmd", 64'(bus.m_raddr), 64'd0);
          else begin
            c = exp_cmd.pop_front();
            chk("cmd_addr", 64'(bus.m_raddr), 64'(c.addr));
            chk("cmd_len", 64'(bus.m_rlen), 64'(c.len));
          end
        end
        if (bus.m_rdval) begin
          if (exp_beat.size() == 0) chk("unexpected_beat", 64'(bus.s_rdval), 64'd0);
          else begin
            b = exp_beat.pop_front();
            chk("rdval", 64'(bus.s_rdval), 64'(b.vld));
            chk("rdata", bus.s_rdata, b.data);
          end
        end else if (bus.s_rdval != 0) begin
          chk("rdval_idle", 64'(bus.s_rdval), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.s_rval  = '0;
    bus.s_rlen  = '0;
    bus.s_raddr = '0;
    bus.m_rrdy  = 1'b0;
    bus.m_rdata = '0;
    bus.m_rdval = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_m_rval", 64'(bus.m_rval), 64'd0);
    chk("rst_s_rrdy", 64'(bus.s_rrdy), 64'd0);
    chk("rst_s_rdval", 64'(bus.s_rdval), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // T1 single burst on ch1
    bus.m_rrdy = 1'b1;
    set_req(1, 32'h100, 9'd8);
    exp_req(1, 32'h100, 9'd8);
    issue(3'b010);
    @(negedge clk);
    chk("t1_latency", 64'(bus.m_rval), 64'd1);
    step();
    burst(3'b010, 8, 64'hA000_0000_0000_0000);
    step();

    // T2 fairness, two rounds so the pointer wraps 2 -> 0
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        set_req(c, 32'h1000 * (c + 1) + 32'h100 * r, 9'd4);
        exp_req(c, 32'h1000 * (c + 1) + 32'h100 * r, 9'd4);
      end
      issue(3'b111);
      step();
      burst(3'b001, 4, 64'hB000 + 64'h100 * r);
      burst(3'b010, 4, 64'hB010 + 64'h100 * r);
      burst(3'b100, 4, 64'hB020 + 64'h100 * r);
    end
    step();

    // T3 backpressure: command held stable, no further grants
    do_reset();
    bus.m_rrdy = 1'b0;
    set_req(0, 32'h2000, 9'd16);
    set_req(1, 32'h3000, 9'd2);
    exp_req(0, 32'h2000, 9'd16);
    issue(3'b001);
    bus.s_rval = 3'b010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_m_rval", 64'(bus.m_rval), 64'd1);
      chk("t3_m_raddr", 64'(bus.m_raddr), 64'h2000);
      chk("t3_m_rlen", 64'(bus.m_rlen), 64'd16);
      chk("t3_no_rrdy", 64'(bus.s_rrdy), 64'd0);
      step();
    end
    exp_req(1, 32'h3000, 9'd2);
    bus.m_rrdy = 1'b1;
    issue(3'b010);
    step();
    burst(3'b001, 16, 64'hC000);
    burst(3'b010, 2, 64'hC100);
    step();

    // T4 tag queue full, no same-cycle bypass on pop
    do_reset();
    bus.m_rrdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_req(c, 32'h4000 + 32'h100 * c, 9'd2);
      exp_req(c, 32'h4000 + 32'h100 * c, 9'd2);
    end
    issue(3'b111);
    set_req(0, 32'h4300, 9'd2);
    exp_req(0, 32'h4300, 9'd2);
    issue(3'b001);
    set_req(1, 32'h4400, 9'd2);
    bus.s_rval = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_full_hold", 64'(bus.s_rrdy), 64'd0);
      step();
    end
    beat(3'b001, 64'hD000);
    bus.m_rdval = 1'b1;
    bus.m_rdata = 64'hD001;
    exp_beat.push_back('{3'b001, 64'hD001});
    @(negedge clk);
    chk("t4_no_bypass", 64'(bus.s_rrdy), 64'd0);
    step();
    bus.m_rdval = 1'b0;
    exp_req(1, 32'h4400, 9'd2);
    @(negedge clk);
    chk("t4_fifth_grant", 64'(bus.s_rrdy), 64'b010);
    step();
    bus.s_rval = '0;
    burst(3'b010, 2, 64'hD100);
    burst(3'b100, 2, 64'hD200);
    burst(3'b001, 2, 64'hD300);
    burst(3'b010, 2, 64'hD400);
    step();

    // T5 zero length on ch2, then T6 stray beat sets sticky err
    do_reset();
    set_req(2, 32'h5000, 9'd0);
    exp_req(2, 32'h5000, 9'd0);
    issue(3'b100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_m_rval", 64'(bus.m_rval), 64'd0);
      step();
    end
    beat(3'b000, 64'hDEAD);
    @(negedge clk);
    chk("t6_err_set", 64'(err), 64'd1);
    repeat (3) step();
    @(negedge clk);
    chk("t6_err_sticky", 64'(err), 64'd1);
    step();

    // T6 reset mid-burst with a command still pending on the master port
    set_req(0, 32'h6000, 9'd8);
    exp_req(0, 32'h6000, 9'd8);
    issue(3'b001);
    step();
    burst(3'b001, 3, 64'hE000);
    bus.m_rrdy = 1'b0;
    set_req(1, 32'h6100, 9'd4);
    exp_gnt.push_back(1);
    issue(3'b010);
    @(negedge clk);
    chk("t6_pending", 64'(bus.m_rval), 64'd1);
    step();
    rst_n       = 1'b0;
    bus.m_rdval = 1'b1;
    bus.m_rdata = 64'hE100;
    bus.s_rval  = 3'b001;
    step();
    @(negedge clk);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_m_rval", 64'(bus.m_rval), 64'd0);
    chk("t6_rst_s_rdval", 64'(bus.s_rdval), 64'd0);
    chk("t6_rst_s_rrdy", 64'(bus.s_rrdy), 64'd0);
    step();
    bus.m_rdval = 1'b0;
    bus.s_rval  = '0;
    rst_n       = 1'b1;
    step();
    beat(3'b000, 64'hBEEF);
    @(negedge clk);
    chk("t6_queue_flushed", 64'(err), 64'd1);
    repeat (3) step();

    chk("left_grants", 64'(exp_gnt.size()), 64'd0);
    chk("left_cmds", 64'(exp_cmd.size()), 64'd0);
    chk("left_beats", 64'(exp_beat.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
